alu_exec: RTL and testbench

Execute-stage ALU that consumes the 8-bit `alucontrol` code produced by the ALU decoder and carries out the operation. Single-cycle ops (logic, shift, add/sub, slt, lui, mult, HI/LO moves) resolve combinationally. Signed and unsigned divide run on an iterative 32-step radix-2 divider that stalls the pipeline. The block owns the architectural HI/LO registers and sits between the ID/EX and EX/MEM pipeline registers.

---
 rtl/alu_exec.sv | 277 +++++++++++++++++++++++++++
 tb/tb_alu_exec.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with HI/LO registers and an optional
// iterative radix-2 divider, compiled in when ALU_DIV_EN is defined.
// Ports: clk, rst (async active-low), alucontrol[7:0], a[31:0], b[31:0],
//   sa[4:0], valid, flush -> result[31:0], overflow, stall.
module alu_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  alucontrol,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  sa,
  input  logic        valid,
  input  logic        flush,
  output logic [31:0] result,
  output logic        overflow,
  output logic        stall
);

  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_ANDI_OP  = 8'b0101_1001;
  localparam logic [7:0] EXE_ORI_OP   = 8'b0101_1010;
  localparam logic [7:0] EXE_XORI_OP  = 8'b0101_1011;
  localparam logic [7:0] EXE_LUI_OP   = 8'b0101_1100;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SLLV_OP  = 8'b0000_0100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRLV_OP  = 8'b0000_0110;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_SRAV_OP  = 8'b0000_0111;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_LW_OP    = 8'b1110_0011;
  localparam logic [7:0] EXE_SW_OP    = 8'b1110_1011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_ovf_add;
  logic        w_ovf_sub;
  logic [63:0] w_mul_s;
  logic [63:0] w_mul_u;
  logic        w_we;
  logic        w_we_hi;
  logic        w_we_lo;
  logic [31:0] w_hi_nx;
  logic [31:0] w_lo_nx;

  logic        w_div_we;
  logic [31:0] w_div_hi;
  logic [31:0] w_div_lo;

  assign w_sum  = a + b;
  assign w_diff = a - b;
  assign w_mul_s = 64'($signed(a) * $signed(b));
  assign w_mul_u = {32'd0, a} * {32'd0, b};

  assign w_ovf_add = (a[31] == b[31]) && (w_sum[31] != a[31]);
  assign w_ovf_sub = (a[31] != b[31]) && (w_diff[31] != a[31]);

  always_comb begin
    overflow = 1'b0;
    case (alucontrol)
      EXE_ADD_OP,
      EXE_ADDI_OP: overflow = w_ovf_add;
      EXE_SUB_OP:  overflow = w_ovf_sub;
      default:     overflow = 1'b0;
    endcase
  end

  always_comb begin
    result = 32'd0;
    case (alucontrol)
      EXE_AND_OP,
      EXE_ANDI_OP: result = a & b;
      EXE_OR_OP,
      EXE_ORI_OP:  result = a | b;
      EXE_XOR_OP,
      EXE_XORI_OP: result = a ^ b;
      EXE_NOR_OP:  result = ~(a | b);
      EXE_LUI_OP:  result = {b[15:0], 16'h0};
      EXE_SLL_OP:  result = b << sa;
      EXE_SLLV_OP: result = b << a[4:0];
      EXE_SRL_OP:  result = b >> sa;
      EXE_SRLV_OP: result = b >> a[4:0];
      EXE_SRA_OP:  result = $signed(b) >>> sa;
      EXE_SRAV_OP: result = $signed(b) >>> a[4:0];
      EXE_ADD_OP,
      EXE_ADDI_OP,
      EXE_LW_OP,
      EXE_SW_OP:   result = w_sum;
      EXE_SUB_OP:  result = w_diff;
      EXE_SLT_OP:  result = {31'd0, $signed(a) < $signed(b)};
      EXE_MFHI_OP: result = r_hi;
      EXE_MFLO_OP: result = r_lo;
      default:     result = 32'd0;
    endcase
  end

  assign w_we = valid & ~flush & ~overflow;

  always_comb begin
    w_we_hi = 1'b0;
    w_we_lo = 1'b0;
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    case (alucontrol)
      EXE_MTHI_OP: begin
        w_we_hi = w_we;
        w_hi_nx = a;
      end
      EXE_MTLO_OP: begin
        w_we_lo = w_we;
        w_lo_nx = a;
      end
      EXE_MULT_OP: begin
        w_we_hi = w_we;
        w_we_lo = w_we;
        w_hi_nx = w_mul_s[63:32];
        w_lo_nx = w_mul_s[31:0];
      end
      EXE_MULTU_OP: begin
        w_we_hi = w_we;
        w_we_lo = w_we;
        w_hi_nx = w_mul_u[63:32];
        w_lo_nx = w_mul_u[31:0];
      end
      default: begin
        w_we_hi = 1'b0;
        w_we_lo = 1'b0;
      end
    endcase
  end

  // A single-cycle write in the same cycle as a divide completion
  // belongs to the younger instruction, so it is applied last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      if (w_div_we) begin
        r_hi <= w_div_hi;
        r_lo <= w_div_lo;
      end
      if (w_we_hi) r_hi <= w_hi_nx;
      if (w_we_lo) r_lo <= w_lo_nx;
    end
  end

`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_st_t;

  div_st_t     r_st;
  div_st_t     w_st_nx;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_is_div;
  logic        w_signed;
  logic        w_b_zero;
  logic        w_start;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_shift;
  logic [32:0] w_trial;

  assign w_is_div = (alucontrol == EXE_DIV_OP) |
                    (alucontrol == EXE_DIVU_OP);
  assign w_signed = (alucontrol == EXE_DIV_OP);
  assign w_b_zero = (b == 32'd0);
  assign w_a_mag  = (w_signed & a[31]) ? -a : a;
  assign w_b_mag  = (w_signed & b[31]) ? -b : b;

  // r_quo shifts dividend bits out at the top and quotient bits in
  // at the bottom; a negative trial means the restore path.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  assign w_div_lo = r_neg_q ? -r_quo : r_quo;
  assign w_div_hi = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_st <= S_IDLE;
    else      r_st <= w_st_nx;
  end

  always_comb begin
    w_st_nx  = r_st;
    w_start  = 1'b0;
    stall    = 1'b0;
    w_div_we = 1'b0;
    case (r_st)
      S_IDLE: begin
        if (valid && w_is_div && !flush) begin
          w_start = 1'b1;
          stall   = ~w_b_zero;
          w_st_nx = w_b_zero ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          w_st_nx = S_IDLE;
        end else begin
          stall = 1'b1;
          if (r_cnt == 5'd31) w_st_nx = S_DONE;
        end
      end
      S_DONE: begin
        w_div_we = ~flush;
        w_st_nx  = S_IDLE;
      end
      default: w_st_nx = S_IDLE;
    endcase
  end

  // Divide by zero preloads the final LO/HI values so DONE needs no
  // special case: quotient all ones, remainder the raw dividend.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= 5'd0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_dvs   <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_start) begin
      r_cnt <= 5'd0;
      if (w_b_zero) begin
        r_rem   <= a;
        r_quo   <= 32'hFFFF_FFFF;
        r_dvs   <= b;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else begin
        r_rem   <= 32'd0;
        r_quo   <= w_a_mag;
        r_dvs   <= w_b_mag;
        r_neg_q <= w_signed & (a[31] ^ b[31]);
        r_neg_r <= w_signed & a[31];
      end
    end else if (r_st == S_BUSY) begin
      r_rem <= w_trial[32] ? w_shift[31:0] : w_trial[31:0];
      r_quo <= {r_quo[30:0], ~w_trial[32]};
      r_cnt <= r_cnt + 5'd1;
    end
  end
`else
  assign stall    = 1'b0;
  assign w_div_we = 1'b0;
  assign w_div_hi = 32'd0;
  assign w_div_lo = 32'd0;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec.
// Expected values adapt to whether ALU_DIV_EN is defined.
module tb_alu_exec;

  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_LUI   = 8'b0101_1100;
  localparam logic [7:0] OP_SRLV  = 8'b0000_0110;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_ADD   = 8'b0010_0000;
  localparam logic [7:0] OP_SUB   = 8'b0010_0010;
  localparam logic [7:0] OP_LW    = 8'b1110_0011;
  localparam logic [7:0] OP_BEQ   = 8'b0101_0001;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;

`ifdef ALU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  alucontrol;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  sa;
  logic        valid;
  logic        flush;
  logic [31:0] result;
  logic        overflow;
  logic        stall;

  int checks = 0;
  int errors = 0;
  int n;

  alu_exec dut (
    .clk        (clk),
    .rst        (rst),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .sa         (sa),
    .valid      (valid),
    .flush      (flush),
    .result     (result),
    .overflow   (overflow),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [4:0] sv);
    alucontrol = op;
    a = av;
    b = bv;
    sa = sv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    valid = 1'b1;
    flush = 1'b0;
    drive(OP_MFHI, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("reset_hi", result, 32'd0);
    chk("reset_stall", stall, 1'b0);
    tick();
    drive(OP_MFLO, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("reset_lo", result, 32'd0);
    tick();
    rst = 1'b1;

    drive(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
    @(negedge clk);
    chk("add_res", result, 32'h8000_0000);
    chk("add_ovf", overflow, 1'b1);
    tick();
    drive(OP_MFLO, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("add_ovf_lo", result, 32'd0);
    tick();
    drive(OP_LW, 32'h7FFF_FFFF, 32'd1, 5'd0);
    @(negedge clk);
    chk("lw_res", result, 32'h8000_0000);
    chk("lw_ovf", overflow, 1'b0);
    tick();
    drive(OP_SUB, 32'h8000_0000, 32'd1, 5'd0);
    @(negedge clk);
    chk("sub_res", result, 32'h7FFF_FFFF);
    chk("sub_ovf", overflow, 1'b1);
    tick();
    drive(OP_SRA, 32'd0, 32'h8000_0000, 5'd4);
    @(negedge clk);
    chk("sra", result, 32'hF800_0000);
    tick();
    drive(OP_SRLV, 32'd36, 32'hF000_0000, 5'd0);
    @(negedge clk);
    chk("srlv", result, 32'h0F00_0000);
    tick();
    drive(OP_LUI, 32'd0, 32'h0000_1234, 5'd0);
    @(negedge clk);
    chk("lui", result, 32'h1234_0000);
    tick();
    drive(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
    @(negedge clk);
    chk("slt", result, 32'd1);
    tick();
    drive(OP_NOR, 32'd0, 32'h0000_00FF, 5'd0);
    @(negedge clk);
    chk("nor", result, 32'hFFFF_FF00);
    tick();
    drive(OP_BEQ, 32'd5, 32'd5, 5'd0);
    @(negedge clk);
    chk("beq", result, 32'd0);
    tick();

    drive(OP_MULT, 32'hFFFF_FFFD, 32'd5, 5'd0);
    tick();
    drive(OP_MFHI, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("mult_hi", result, 32'hFFFF_FFFF);
    tick();
    drive(OP_MFLO, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("mult_lo", result, 32'hFFFF_FFF1);
    tick();
    drive(OP_MULTU, 32'hFFFF_FFFD, 32'd5, 5'd0);
    tick();
    drive(OP_MFHI, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("multu_hi", result, 32'h0000_0004);
    tick();
    drive(OP_MFLO, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("multu_lo", result, 32'hFFFF_FFF1);
    tick();

    drive(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 5'd0);
    tick();
    drive(OP_MFHI, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("mthi", result, 32'hDEAD_BEEF);
    tick();
    flush = 1'b1;
    drive(OP_MTLO, 32'h0000_1234, 32'd0, 5'd0);
    tick();
    flush = 1'b0;
    drive(OP_MFLO, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("mtlo_flushed", result, 32'hFFFF_FFF1);
    tick();

    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
    @(negedge clk);
    chk("div_result0", result, 32'd0);
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("div_stall_len", n, DivEn ? 33 : 0);
    tick();
    drive(OP_MFLO, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("div_lo", result, DivEn ? 32'hFFFF_FFFD : 32'hFFFF_FFF1);
    tick();
    drive(OP_MFHI, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("div_hi", result, DivEn ? 32'hFFFF_FFFF : 32'hDEAD_BEEF);
    tick();

    drive(OP_DIVU, 32'd100, 32'd7, 5'd0);
    n = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("divu_stall_len", n, DivEn ? 33 : 0);
    tick();
    drive(OP_MFLO, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("divu_lo", result, DivEn ? 32'd14 : 32'hFFFF_FFF1);
    tick();
    drive(OP_MFHI, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("divu_hi", result, DivEn ? 32'd2 : 32'hDEAD_BEEF);
    tick();

    drive(OP_DIVU, 32'd9, 32'd0, 5'd0);
    @(negedge clk);
    chk("dz_stall", stall, 1'b0);
    tick();
    drive(OP_MFHI, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("dz_nobypass", result, DivEn ? 32'd2 : 32'hDEAD_BEEF);
    tick();
    @(negedge clk);
    chk("dz_hi", result, DivEn ? 32'd9 : 32'hDEAD_BEEF);
    tick();
    drive(OP_MFLO, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("dz_lo", result, DivEn ? 32'hFFFF_FFFF : 32'hFFFF_FFF1);
    tick();

    drive(OP_DIV, 32'd50, 32'd3, 5'd0);
    repeat (9) tick();
    @(negedge clk);
    chk("fl_stall9", stall, DivEn);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_stall10", stall, 1'b0);
    tick();
    flush = 1'b0;
    drive(OP_MFHI, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("fl_hi", result, DivEn ? 32'd9 : 32'hDEAD_BEEF);
    chk("fl_idle", stall, 1'b0);
    tick();
    drive(OP_MFLO, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("fl_lo", result, DivEn ? 32'hFFFF_FFFF : 32'hFFFF_FFF1);
    tick();

    drive(OP_DIV, 32'd20, 32'd3, 5'd0);
    repeat (15) tick();
    rst = 1'b0;
    drive(OP_MFHI, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("rst_hi", result, 32'd0);
    chk("rst_stall", stall, 1'b0);
    tick();
    rst = 1'b1;
    drive(OP_MFLO, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("rst_lo", result, 32'd0);
    tick();

    drive(OP_DIV, 32'd20, 32'd3, 5'd0);
    n = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("rediv_stall_len", n, DivEn ? 33 : 0);
    tick();
    drive(OP_MFLO, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("rediv_lo", result, DivEn ? 32'd6 : 32'd0);
    tick();
    drive(OP_MFHI, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("rediv_hi", result, DivEn ? 32'd2 : 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
